dds_sweep_ctrl: RTL

//  Sequencer for the DDS tone generators. It steps a phase-increment (PINC) through START..STOP
//  in STEP increments, holding each value for DWELL cycles.

---
 rtl/dds_sweep_ctrl_if.sv | 8 +
 rtl/dds_sweep_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: AXI-Stream config channel from the sweep sequencer to the DDS.
interface dds_sweep_ctrl_if #(parameter int PINC_W = 16);
  logic              tvalid;
  logic              tready;
  logic [PINC_W-1:0] tdata;
  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps DDS PINC from START to STOP, holding each value DWELL cycles.
// Optional key debounce is built when DDS_KEY_DEBOUNCE_EN is defined.
module dds_sweep_ctrl #(
  parameter int PINC_W     = 16,
  parameter int START_PINC = 655,
  parameter int STEP_PINC  = 655,
  parameter int STOP_PINC  = 5242,
  parameter int DWELL      = 1000,
  parameter int DB_CYC     = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_i,
  input  logic             enable_i,
  dds_sweep_ctrl_if.master cfg,
  output logic             busy_o,
  output logic             sweep_done_o
);
  localparam int CNT_W = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [PINC_W-1:0] START_V = PINC_W'(START_PINC);
  localparam logic [PINC_W:0]   STEP_X  = (PINC_W+1)'(STEP_PINC);
  localparam logic [PINC_W:0]   STOP_X  = (PINC_W+1)'(STOP_PINC);
  localparam logic [CNT_W-1:0]  DWELL_LD = CNT_W'(DWELL - 1);

  if (DWELL < 1 || DB_CYC < 1) begin : g_bad_param
    $error("dds_sweep_ctrl: DWELL and DB_CYC must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;

  logic [1:0] sync_q;
  logic       prev_q;
  logic       key_lvl;
  logic       key_evt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], key_i};

`ifdef DDS_KEY_DEBOUNCE_EN
  localparam int DB_W = DB_CYC > 1 ? $clog2(DB_CYC) : 1;
  logic            db_q, db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  // Any sample matching the current level restarts the stability window.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (db_cnt_q == DB_W'(DB_CYC - 1)) db_d = sync_q[1];
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  assign key_lvl = db_q;
`else
  assign key_lvl = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= key_lvl;

  assign key_evt = key_lvl & ~prev_q;

  state_t            state_q, state_d;
  logic [PINC_W-1:0] pinc_q, pinc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              abort_req;
  logic [PINC_W:0]   next_sum;

  assign abort_req = key_evt | ~enable_i;
  // One extra bit so a wrap past 2^PINC_W compares as above STOP.
  assign next_sum  = {1'b0, pinc_q} + STEP_X;

  always_comb begin
    state_d = state_q;
    pinc_d  = pinc_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    unique case (state_q)
      S_IDLE:
        if (key_evt && enable_i) begin
          state_d = S_LOAD;
          pinc_d  = START_V;
          abort_d = 1'b0;
        end
      S_LOAD: begin
        abort_d = abort_q | abort_req;
        if (cfg.tready) begin
          state_d = (abort_q | abort_req) ? S_IDLE : S_DWELL;
          cnt_d   = DWELL_LD;
          abort_d = 1'b0;
        end
      end
      S_DWELL:
        if (abort_req) state_d = S_IDLE;
        else if (cnt_q == '0) begin
          state_d = (next_sum > STOP_X) ? S_DONE : S_LOAD;
          pinc_d  = (next_sum > STOP_X) ? pinc_q : next_sum[PINC_W-1:0];
        end else cnt_d = cnt_q - 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      pinc_q  <= START_V;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pinc_q  <= pinc_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end

  assign cfg.tvalid   = state_q == S_LOAD;
  assign cfg.tdata    = pinc_q;
  assign busy_o       = state_q != S_IDLE;
  assign sweep_done_o = state_q == S_DONE;
endmodule
